mips_multicycle_processor: RTL and testbench

Multicycle MIPS-32 core, the parametrised successor to the single-cycle processor. One shared ALU is sequenced by an internal FSM, so each instruction class takes a fixed number of cycles. The core has a parametrised internal data RAM, parametrised-width memory-mapped input/output ports, and a retire pulse for verification. Program memory is external and read combinationally, indexed by PC.

---
 rtl/mips_multicycle_processor.sv | 214 +++++++++++++++++++++
 tb/tb_mips_multicycle_processor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_processor.sv
// Multicycle MIPS-32 core: one shared ALU sequenced by a five-state FSM,
// with an internal data RAM and memory-mapped input/output ports.
module mips_multicycle_processor #(
    parameter logic [31:0] RESET_PC       = 32'h0040_0000,
    parameter logic [31:0] DMEM_BASE      = 32'h1001_0000,
    parameter int          DMEM_DEPTH     = 64,
    parameter logic [31:0] IO_OUT_ADDR    = 32'h1001_0100,
    parameter logic [31:0] IO_IN_ADDR     = 32'h1001_0104,
    parameter int          PORT_IN_WIDTH  = 8,
    parameter int          PORT_OUT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [31:0]               imem_addr,
    input  logic [31:0]               imem_rdata,
    input  logic [PORT_IN_WIDTH-1:0]  PortIn,
    output logic [PORT_OUT_WIDTH-1:0] PortOut,
    output logic [31:0]               ALUResultOut,
    output logic                      retire,
    output logic                      illegal
);
    localparam int AW = $clog2(DMEM_DEPTH);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLL, OP_SRL,
        OP_JR, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI, OP_LW, OP_SW,
        OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ILL
    } op_t;

    state_t state, state_next;
    op_t op;

    logic [31:0] pc, ir, a, b, tgt, alu_out, mdr;
    logic [31:0] rf [32];
    logic [31:0] ram [DMEM_DEPTH];

    logic [31:0] imm_s, imm_z, alu_res, rs_val, rt_val, rd_data;
    logic [4:0]  dst;
    logic [AW-1:0] ram_idx;
    logic io_out, io_in, is_jump, is_branch;

    assign imem_addr    = pc;
    assign ALUResultOut = alu_out;

    assign imm_s  = {{16{ir[15]}}, ir[15:0]};
    assign imm_z  = {16'h0000, ir[15:0]};
    assign rs_val = rf[ir[25:21]];
    assign rt_val = rf[ir[20:16]];
    assign dst    = (ir[31:26] == 6'h00) ? ir[15:11] : ir[20:16];

    assign is_jump   = op inside {OP_J, OP_JAL, OP_JR, OP_ILL};
    assign is_branch = op inside {OP_BEQ, OP_BNE};

    // Low two address bits are don't-care for both IO and RAM decode.
    assign io_out  = alu_out[31:2] == IO_OUT_ADDR[31:2];
    assign io_in   = alu_out[31:2] == IO_IN_ADDR[31:2];
    assign ram_idx = AW'((alu_out - DMEM_BASE) >> 2);

    always_comb begin
        if (io_in)
            rd_data = 32'(PortIn);
        else if (io_out)
            rd_data = 32'(PortOut);
        else
            rd_data = ram[ram_idx];
    end

    always_comb begin
        op = OP_ILL;
        case (ir[31:26])
            6'h00: begin
                case (ir[5:0])
                    6'h20: op = OP_ADD;
                    6'h22: op = OP_SUB;
                    6'h24: op = OP_AND;
                    6'h25: op = OP_OR;
                    6'h27: op = OP_NOR;
                    6'h2A: op = OP_SLT;
                    6'h00: op = OP_SLL;
                    6'h02: op = OP_SRL;
                    6'h08: op = OP_JR;
                    default: op = OP_ILL;
                endcase
            end
            6'h08: op = OP_ADDI;
            6'h0C: op = OP_ANDI;
            6'h0D: op = OP_ORI;
            6'h0A: op = OP_SLTI;
            6'h0F: op = OP_LUI;
            6'h23: op = OP_LW;
            6'h2B: op = OP_SW;
            6'h04: op = OP_BEQ;
            6'h05: op = OP_BNE;
            6'h02: op = OP_J;
            6'h03: op = OP_JAL;
            default: op = OP_ILL;
        endcase
    end

    // addi, lw and sw all share the default a + sext(imm) path.
    always_comb begin
        alu_res = a + imm_s;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
            OP_SLL:  alu_res = b << ir[10:6];
            OP_SRL:  alu_res = b >> ir[10:6];
            OP_ANDI: alu_res = a & imm_z;
            OP_ORI:  alu_res = a | imm_z;
            OP_SLTI: alu_res = {31'd0, $signed(a) < $signed(imm_s)};
            OP_LUI:  alu_res = {ir[15:0], 16'h0000};
            default: ;
        endcase
    end

    always_comb begin
        state_next = S_FETCH;
        retire     = 1'b0;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                state_next = is_jump ? S_FETCH : S_EXEC;
                retire     = is_jump;
            end
            S_EXEC: begin
                if (is_branch) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end else if (op == OP_LW || op == OP_SW) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                state_next = (op == OP_SW) ? S_FETCH : S_WB;
                retire     = (op == OP_SW);
            end
            S_WB: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            tgt     <= '0;
            alu_out <= '0;
            mdr     <= '0;
            PortOut <= '0;
            illegal <= 1'b0;
            for (int i = 0; i < 32; i++)
                rf[i] <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_FETCH: begin
                    ir <= imem_rdata;
                    pc <= pc + 32'd4;
                end
                S_DECODE: begin
                    a   <= rs_val;
                    b   <= rt_val;
                    tgt <= pc + {imm_s[29:0], 2'b00};
                    if (op == OP_J || op == OP_JAL)
                        pc <= {pc[31:28], ir[25:0], 2'b00};
                    if (op == OP_JAL)
                        rf[31] <= pc;
                    if (op == OP_JR)
                        pc <= rs_val;
                    if (op == OP_ILL)
                        illegal <= 1'b1;
                end
                S_EXEC: begin
                    if ((op == OP_BEQ && a == b) || (op == OP_BNE && a != b))
                        pc <= tgt;
                    if (!is_branch)
                        alu_out <= alu_res;
                end
                S_MEM: begin
                    if (op == OP_SW && io_out)
                        PortOut <= b[PORT_OUT_WIDTH-1:0];
                    if (op == OP_LW)
                        mdr <= rd_data;
                end
                S_WB: begin
                    if (dst != 5'd0)
                        rf[dst] <= (op == OP_LW) ? mdr : alu_out;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_MEM && op == OP_SW && !io_out && !io_in)
            ram[ram_idx] <= b;
    end
endmodule

// File: tb/tb_mips_multicycle_processor.sv
// Directed bench for the multicycle MIPS core: small programs in a
// combinational instruction ROM, results observed on the output ports.
module tb_mips_multicycle_processor;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [7:0]  PortIn = 8'h00;
    logic [31:0] PortOut;
    logic [31:0] ALUResultOut;
    logic        retire;
    logic        illegal;

    logic [31:0] prog [64];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    localparam logic [31:0] RPC = 32'h0040_0000;

    mips_multicycle_processor dut (
        .clk(clk),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .PortIn(PortIn),
        .PortOut(PortOut),
        .ALUResultOut(ALUResultOut),
        .retire(retire),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign imem_rdata = prog[6'((imem_addr - RPC) >> 2)];

    function automatic logic [31:0] ri(input logic [5:0] o,
            input logic [4:0] rs, input logic [4:0] rt,
            input logic [15:0] imm);
        return {o, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rr(input logic [4:0] rs,
            input logic [4:0] rt, input logic [4:0] rd,
            input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] jj(input logic [5:0] o,
            input logic [31:0] addr);
        return {o, addr[27:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
            input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++)
            prog[i] = 32'h0000_0000;
    endtask

    // Reset held two edges, released at a negedge: that point is cycle 1.
    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc = 1;
    endtask

    task automatic goto_cyc(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        clear_prog();
        @(negedge clk);
        check("rst_pc", imem_addr, RPC);
        check("rst_portout", PortOut, 32'h0);
        check("rst_alu", ALUResultOut, 32'h0);
        check("rst_retire", {31'd0, retire}, 32'h0);
        check("rst_illegal", {31'd0, illegal}, 32'h0);

        // ALU program: retire every 4 cycles
        clear_prog();
        prog[0] = ri(6'h08, 5'd0, 5'd8, 16'd5);
        prog[1] = ri(6'h08, 5'd0, 5'd9, 16'hFFFD);
        prog[2] = rr(5'd8, 5'd9, 5'd10, 5'd0, 6'h20);
        prog[3] = rr(5'd9, 5'd8, 5'd11, 5'd0, 6'h2A);
        prog[4] = ri(6'h0F, 5'd0, 5'd16, 16'h1001);
        prog[5] = ri(6'h2B, 5'd16, 5'd10, 16'h0100);
        prog[6] = ri(6'h2B, 5'd16, 5'd11, 16'h0100);
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            goto_cyc(c);
            check("alu_retire", {31'd0, retire}, (c % 4 == 0) ? 32'd1 : 32'd0);
            if (c == 12)
                check("alu_add", ALUResultOut, 32'd2);
        end
        check("alu_slt", ALUResultOut, 32'd1);
        goto_cyc(20);
        check("alu_lui", ALUResultOut, 32'h1001_0000);
        goto_cyc(24);
        check("sw_before", PortOut, 32'h0);
        goto_cyc(25);
        check("out_t2", PortOut, 32'd2);
        goto_cyc(29);
        check("out_t3", PortOut, 32'd1);

        // Memory program: sw/lw, 5-cycle lw, address aliasing
        clear_prog();
        prog[0] = ri(6'h08, 5'd0, 5'd8, 16'h1234);
        prog[1] = ri(6'h0F, 5'd0, 5'd16, 16'h1001);
        prog[2] = ri(6'h2B, 5'd16, 5'd8, 16'h0008);
        prog[3] = ri(6'h23, 5'd16, 5'd9, 16'h0008);
        prog[4] = ri(6'h2B, 5'd16, 5'd9, 16'h0100);
        prog[5] = ri(6'h08, 5'd0, 5'd11, 16'h0055);
        prog[6] = ri(6'h2B, 5'd16, 5'd11, 16'h0200);
        prog[7] = ri(6'h23, 5'd16, 5'd10, 16'h0000);
        prog[8] = ri(6'h2B, 5'd16, 5'd10, 16'h0100);
        do_reset();
        goto_cyc(12);
        check("sw_retire", {31'd0, retire}, 32'd1);
        goto_cyc(16);
        check("lw_not_yet", {31'd0, retire}, 32'd0);
        goto_cyc(17);
        check("lw_retire", {31'd0, retire}, 32'd1);
        check("lw_addr", ALUResultOut, 32'h1001_0008);
        goto_cyc(22);
        check("lw_data", PortOut, 32'h0000_1234);
        goto_cyc(39);
        check("alias_w0", PortOut, 32'h0000_0055);

        // Branches and jumps
        clear_prog();
        prog[0]  = ri(6'h04, 5'd0, 5'd0, 16'd2);
        prog[1]  = ri(6'h08, 5'd0, 5'd8, 16'd1);
        prog[2]  = ri(6'h08, 5'd0, 5'd8, 16'd1);
        prog[3]  = ri(6'h05, 5'd0, 5'd0, 16'd2);
        prog[4]  = jj(6'h03, 32'h0040_0020);
        prog[5]  = jj(6'h02, 32'h0040_0014);
        prog[8]  = ri(6'h0F, 5'd0, 5'd16, 16'h1001);
        prog[9]  = ri(6'h2B, 5'd16, 5'd31, 16'h0100);
        prog[10] = rr(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        do_reset();
        goto_cyc(2);
        check("beq_c2", {31'd0, retire}, 32'd0);
        goto_cyc(3);
        check("beq_retire", {31'd0, retire}, 32'd1);
        goto_cyc(4);
        check("beq_pc", imem_addr, 32'h0040_000C);
        goto_cyc(6);
        check("bne_retire", {31'd0, retire}, 32'd1);
        goto_cyc(7);
        check("bne_pc", imem_addr, 32'h0040_0010);
        goto_cyc(8);
        check("jal_retire", {31'd0, retire}, 32'd1);
        goto_cyc(9);
        check("jal_pc", imem_addr, 32'h0040_0020);
        goto_cyc(17);
        check("jal_ra", PortOut, 32'h0040_0014);
        goto_cyc(18);
        check("jr_retire", {31'd0, retire}, 32'd1);
        goto_cyc(19);
        check("jr_pc", imem_addr, 32'h0040_0014);

        // IO ports
        PortIn = 8'hA5;
        clear_prog();
        prog[0] = ri(6'h0F, 5'd0, 5'd16, 16'h1001);
        prog[1] = ri(6'h23, 5'd16, 5'd8, 16'h0104);
        prog[2] = ri(6'h2B, 5'd16, 5'd8, 16'h0100);
        prog[3] = ri(6'h0F, 5'd0, 5'd9, 16'hDEAD);
        prog[4] = ri(6'h0D, 5'd9, 5'd9, 16'hBEEF);
        prog[5] = ri(6'h2B, 5'd16, 5'd9, 16'h0100);
        prog[6] = ri(6'h2B, 5'd16, 5'd0, 16'h0104);
        prog[7] = ri(6'h23, 5'd16, 5'd10, 16'h0100);
        prog[8] = ri(6'h08, 5'd10, 5'd10, 16'h0001);
        do_reset();
        goto_cyc(14);
        check("portin", PortOut, 32'h0000_00A5);
        goto_cyc(21);
        check("ori_zext", ALUResultOut, 32'hDEAD_BEEF);
        goto_cyc(25);
        check("out_hold", PortOut, 32'h0000_00A5);
        goto_cyc(26);
        check("out_write", PortOut, 32'hDEAD_BEEF);
        goto_cyc(38);
        check("out_readback", ALUResultOut, 32'hDEAD_BEF0);

        // Illegal opcode, then reset during EXEC of an add
        clear_prog();
        prog[0] = ri(6'h0F, 5'd0, 5'd16, 16'h1001);
        prog[1] = ri(6'h08, 5'd0, 5'd8, 16'd7);
        prog[2] = ri(6'h2B, 5'd16, 5'd8, 16'h0100);
        prog[3] = 32'hFC00_0000;
        prog[4] = rr(5'd8, 5'd8, 5'd9, 5'd0, 6'h20);
        do_reset();
        goto_cyc(13);
        check("ill_pre_out", PortOut, 32'd7);
        goto_cyc(14);
        check("ill_retire", {31'd0, retire}, 32'd1);
        check("ill_not_yet", {31'd0, illegal}, 32'd0);
        goto_cyc(15);
        check("ill_flag", {31'd0, illegal}, 32'd1);
        check("ill_pc", imem_addr, 32'h0040_0010);
        check("ill_alu", ALUResultOut, 32'h1001_0100);
        check("ill_out", PortOut, 32'd7);
        goto_cyc(17);
        reset = 1'b0;
        #1;
        check("mid_rst_pc", imem_addr, RPC);
        check("mid_rst_ill", {31'd0, illegal}, 32'd0);
        check("mid_rst_out", PortOut, 32'd0);
        check("mid_rst_alu", ALUResultOut, 32'd0);
        check("mid_rst_ret", {31'd0, retire}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_pc", imem_addr, RPC);
        check("rst_hold_alu", ALUResultOut, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
